// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default widths, fetch FSM states and the
// {instr, pc} entry type that travels from fetch to decode.
package cpu_pkg;

    localparam int CPU_ADDR_W  = 8;
    localparam int CPU_INSTR_W = 16;

    typedef enum logic [0:0] {
        FS_IDLE = 1'b0,
        FS_RUN  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [CPU_INSTR_W-1:0] instr;
        logic [CPU_ADDR_W-1:0]  pc;
    } fetch_entry_t;

    // Successor address with natural wrap at 2**w.
    function automatic logic [CPU_ADDR_W-1:0] pc_inc(input logic [CPU_ADDR_W-1:0] pc);
        return pc + CPU_ADDR_W'(1);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO between the BRAM capture point and decode.
// Push and pop may happen in the same cycle at any occupancy; clear empties
// the queue and takes precedence over a simultaneous push or pop.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int DATA_W = CPU_INSTR_W + CPU_ADDR_W,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clear,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_head,
    output logic              o_valid,
    output logic [CNT_W-1:0]  o_count
);

    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic              do_push;
    logic              do_pop;

    assign do_push = i_push && !i_clear;
    assign do_pop  = i_pop && !i_clear && (count_reg != '0);

    // Pointer advance and occupancy bookkeeping.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (i_clear) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_next = (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_next = (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_next = count_reg + CNT_W'(1);
                2'b01:   count_next = count_reg - CNT_W'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Entry storage; cleared on reset so the head reads zero after reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (do_push) begin
            mem_reg[wr_ptr_reg] <= i_push_data;
        end
    end

    assign o_head  = mem_reg[rd_ptr_reg];
    assign o_valid = (count_reg != '0);
    assign o_count = count_reg;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, drives the BRAM address, tags the
// one-cycle-latency read in flight and queues {instr, pc} for decode.
// Issue is credit-limited so a landing read always has a queue slot.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = CPU_ADDR_W,
    parameter int                INSTR_W  = CPU_INSTR_W,
    parameter int                Q_DEPTH  = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic               i_redirect,
    input  logic [ADDR_W-1:0]  i_redirect_pc,
    output logic [ADDR_W-1:0]  o_addr_read,
    input  logic [INSTR_W-1:0] i_instr_read,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [INSTR_W-1:0] o_instr,
    output logic [ADDR_W-1:0]  o_pc,
    output logic               o_busy
);

    localparam int CNT_W   = $clog2(Q_DEPTH + 1);
    localparam int ENTRY_W = INSTR_W + ADDR_W;

    fetch_state_t        state_reg, state_next;
    logic [ADDR_W-1:0]   pc_reg, pc_next;
    logic                inflight_reg, inflight_next;
    logic [ADDR_W-1:0]   inflight_pc_reg, inflight_pc_next;

    logic                q_valid;
    logic [CNT_W-1:0]    q_count;
    logic [ENTRY_W-1:0]  q_head;
    logic                pop;
    logic                issue;
    logic [CNT_W:0]      credit_used;

    // Slots already spoken for: queued entries plus the read in flight,
    // minus the head leaving this cycle.
    assign pop         = q_valid && i_ready;
    assign credit_used = (CNT_W + 1)'(q_count) + (CNT_W + 1)'(inflight_reg) - (CNT_W + 1)'(pop);
    assign issue       = (state_reg == FS_RUN) && !i_stop && !i_redirect
                         && (credit_used < (CNT_W + 1)'(Q_DEPTH));

    // Run/idle control; stop wins over a simultaneous start.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FS_IDLE: if (i_start && !i_stop) state_next = FS_RUN;
            FS_RUN:  if (i_stop)             state_next = FS_IDLE;
            default: state_next = FS_IDLE;
        endcase
    end

    // PC and in-flight tag; redirect retargets the PC and orphans any landing read.
    always_comb begin
        pc_next          = pc_reg;
        inflight_next    = 1'b0;
        inflight_pc_next = inflight_pc_reg;
        if (i_redirect) begin
            pc_next = i_redirect_pc;
        end else if (issue) begin
            inflight_next    = 1'b1;
            inflight_pc_next = pc_reg;
            pc_next          = pc_reg + ADDR_W'(1);
        end
    end

    // State, PC and in-flight registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg       <= FS_IDLE;
            pc_reg          <= RESET_PC;
            inflight_reg    <= 1'b0;
            inflight_pc_reg <= '0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            inflight_reg    <= inflight_next;
            inflight_pc_reg <= inflight_pc_next;
        end
    end

    // Landing BRAM data is captured whenever a read was in flight; the
    // queue drops it if a redirect clears the queue on the same edge.
    fetch_queue #(
        .DEPTH  (Q_DEPTH),
        .DATA_W (ENTRY_W)
    ) u_fetch_queue (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clear     (i_redirect),
        .i_push      (inflight_reg),
        .i_push_data ({i_instr_read, inflight_pc_reg}),
        .i_pop       (pop),
        .o_head      (q_head),
        .o_valid     (q_valid),
        .o_count     (q_count)
    );

    assign o_addr_read = pc_reg;
    assign o_valid     = q_valid;
    assign o_instr     = q_head[ENTRY_W-1:ADDR_W];
    assign o_pc        = q_head[ADDR_W-1:0];
    assign o_busy      = (state_reg == FS_RUN) || inflight_reg || q_valid;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch. Two instances: the main one (RESET_PC=0)
// and a wrap instance (RESET_PC=8'hFE). Each has a BRAM model with a
// 1-cycle registered read returning 16'hA000 | addr.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, stop, redirect, ready;
    logic [7:0]  redirect_pc;
    logic [7:0]  addr_read;
    logic [15:0] instr_read;
    logic        valid;
    logic [15:0] instr;
    logic [7:0]  pc;
    logic        busy;

    logic        start_w;
    logic        stop_w     = 1'b0;
    logic        redirect_w = 1'b0;
    logic        ready_w    = 1'b1;
    logic [7:0]  redirect_pc_w = 8'h00;
    logic [7:0]  addr_read_w;
    logic [15:0] instr_read_w;
    logic        valid_w;
    logic [15:0] instr_w;
    logic [7:0]  pc_w;
    logic        busy_w;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    instr_fetch #(.ADDR_W(8), .INSTR_W(16), .Q_DEPTH(2), .RESET_PC(8'h00)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop),
        .i_redirect(redirect), .i_redirect_pc(redirect_pc),
        .o_addr_read(addr_read), .i_instr_read(instr_read),
        .o_valid(valid), .i_ready(ready), .o_instr(instr), .o_pc(pc), .o_busy(busy)
    );

    instr_fetch #(.ADDR_W(8), .INSTR_W(16), .Q_DEPTH(2), .RESET_PC(8'hFE)) u_dut_wrap (
        .i_clk(clk), .i_rst(rst), .i_start(start_w), .i_stop(stop_w),
        .i_redirect(redirect_w), .i_redirect_pc(redirect_pc_w),
        .o_addr_read(addr_read_w), .i_instr_read(instr_read_w),
        .o_valid(valid_w), .i_ready(ready_w), .o_instr(instr_w), .o_pc(pc_w), .o_busy(busy_w)
    );

    // BRAM models: registered read of mem[a] = 16'hA000 | a.
    always @(posedge clk) begin
        instr_read   <= 16'hA000 | {8'h00, addr_read};
        instr_read_w <= 16'hA000 | {8'h00, addr_read_w};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance one clock edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expect a valid head carrying address p.
    task automatic expect_head(input string tag, input logic [7:0] p);
        check({tag, ".valid"}, 32'(valid), 32'd1);
        check({tag, ".pc"},    32'(pc),    32'(p));
        check({tag, ".instr"}, 32'(instr), 32'hA000 | 32'(p));
        $display("%s: valid=%0d pc=%02h instr=%04h", tag, valid, pc, instr);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; redirect = 1'b0;
        redirect_pc = 8'h00; ready = 1'b1; start_w = 1'b0;
        step(); step(); step();

        // Reset state
        check("rst.valid", 32'(valid), 32'd0);
        check("rst.instr", 32'(instr), 32'd0);
        check("rst.pc",    32'(pc),    32'd0);
        check("rst.busy",  32'(busy),  32'd0);
        check("rst.addr",  32'(addr_read), 32'h00);
        check("rst.addr_wrap", 32'(addr_read_w), 32'hFE);
        $display("reset: valid=%0d busy=%0d addr=%02h", valid, busy, addr_read);

        // Test 1: start, full-rate stream, o_valid two edges after start edge
        rst = 1'b0; start = 1'b1;
        step();                                   // start edge
        start = 1'b0;
        check("t1.valid_e0", 32'(valid), 32'd0);
        check("t1.busy_e0",  32'(busy),  32'd1);
        step();
        check("t1.valid_e1", 32'(valid), 32'd0);
        step(); expect_head("t1.h0", 8'h00);
        step(); expect_head("t1.h1", 8'h01);
        step(); expect_head("t1.h2", 8'h02);
        step(); expect_head("t2.h3", 8'h03);

        // Test 2: back-pressure for 5 cycles at pc 3
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            expect_head("t2.stall", 8'h03);
            check("t2.stall_addr", 32'(addr_read), 32'h05);
        end
        ready = 1'b1;
        step(); expect_head("t2.h4", 8'h04);
        step(); expect_head("t2.h5", 8'h05);
        step(); expect_head("t2.h6", 8'h06);

        // Test 3: redirect with an entry queued and a read in flight
        ready = 1'b0; redirect = 1'b1; redirect_pc = 8'h40;
        step();
        redirect = 1'b0; ready = 1'b1;
        check("t3.valid_r", 32'(valid), 32'd0);
        check("t3.addr_r",  32'(addr_read), 32'h40);
        step();
        check("t3.valid_r1", 32'(valid), 32'd0);
        check("t3.addr_r1",  32'(addr_read), 32'h41);
        step(); expect_head("t3.h40", 8'h40);
        step(); expect_head("t3.h41", 8'h41);

        // Test 5: stop with one queued and one in flight
        stop = 1'b1;
        step();
        stop = 1'b0;
        expect_head("t5.h42", 8'h42);
        check("t5.busy_drain", 32'(busy), 32'd1);
        step();
        check("t5.valid_end", 32'(valid), 32'd0);
        check("t5.busy_end",  32'(busy),  32'd0);
        check("t5.addr_end",  32'(addr_read), 32'h43);
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        check("t5.busy_both", 32'(busy), 32'd0);
        step();
        check("t5.valid_idle", 32'(valid), 32'd0);
        check("t5.busy_idle",  32'(busy),  32'd0);
        check("t5.addr_idle",  32'(addr_read), 32'h43);
        $display("t5: idle busy=%0d addr=%02h", busy, addr_read);

        // Test 6: reset mid-run with an entry queued and a read in flight
        start = 1'b1; ready = 1'b0;
        step();
        start = 1'b0;
        step();
        step();
        expect_head("t6.h43", 8'h43);
        rst = 1'b1;
        step();
        check("t6.valid_rst", 32'(valid), 32'd0);
        check("t6.busy_rst",  32'(busy),  32'd0);
        check("t6.addr_rst",  32'(addr_read), 32'h00);
        rst = 1'b0; ready = 1'b1;
        step();
        check("t6.valid_post", 32'(valid), 32'd0);
        check("t6.busy_post",  32'(busy),  32'd0);
        $display("t6: after reset valid=%0d busy=%0d addr=%02h", valid, busy, addr_read);

        // Test 4: RESET_PC=FE wraps through 00 without a stall
        check("t4.addr_rst", 32'(addr_read_w), 32'hFE);
        start_w = 1'b1;
        step();
        start_w = 1'b0;
        step();
        step();
        check("t4.pcFE", 32'(pc_w), 32'hFE);
        check("t4.vFE",  32'(valid_w), 32'd1);
        step();
        check("t4.pcFF", 32'(pc_w), 32'hFF);
        check("t4.vFF",  32'(valid_w), 32'd1);
        step();
        check("t4.pc00", 32'(pc_w), 32'h00);
        check("t4.in00", 32'(instr_w), 32'hA000);
        check("t4.v00",  32'(valid_w), 32'd1);
        step();
        check("t4.pc01", 32'(pc_w), 32'h01);
        check("t4.in01", 32'(instr_w), 32'hA001);
        $display("t4: wrap head pc=%02h instr=%04h", pc_w, instr_w);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
